// File: rtl/sdes_pkg.sv
// sdes_pkg: S-DES permutation tables, S-boxes, FSM states and bit-permutation helpers.
// Bit numbering follows the S-DES texts: position 1 is the MSB of every vector.
package sdes_pkg;

  typedef enum logic [2:0] {IDLE, KEYGEN, ROUND1, ROUND2, DONE} state_t;

  localparam int P10    [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8     [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int IP     [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  localparam int IP_INV [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  localparam int EP     [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
  localparam int P4     [4]  = '{2, 4, 3, 1};

  // Indexed by {row, col}, four entries per row.
  localparam logic [1:0] S0 [16] = '{2'd1, 2'd0, 2'd3, 2'd2,
                                     2'd3, 2'd2, 2'd1, 2'd0,
                                     2'd0, 2'd2, 2'd1, 2'd3,
                                     2'd3, 2'd1, 2'd3, 2'd2};
  localparam logic [1:0] S1 [16] = '{2'd0, 2'd1, 2'd2, 2'd3,
                                     2'd2, 2'd0, 2'd1, 2'd3,
                                     2'd3, 2'd0, 2'd1, 2'd0,
                                     2'd2, 2'd1, 2'd0, 2'd3};

  function automatic logic [9:0] perm_p10(input logic [9:0] x);
    logic [9:0] y;
    y = '0;
    for (int i = 0; i < 10; i++) y[4'(9 - i)] = x[4'(10 - P10[i])];
    return y;
  endfunction

  function automatic logic [7:0] perm_p8(input logic [9:0] x);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) y[3'(7 - i)] = x[4'(10 - P8[i])];
    return y;
  endfunction

  function automatic logic [7:0] perm_ip(input logic [7:0] x);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) y[3'(7 - i)] = x[3'(8 - IP[i])];
    return y;
  endfunction

  function automatic logic [7:0] perm_ip_inv(input logic [7:0] x);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) y[3'(7 - i)] = x[3'(8 - IP_INV[i])];
    return y;
  endfunction

  function automatic logic [7:0] perm_ep(input logic [3:0] x);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 8; i++) y[3'(7 - i)] = x[2'(4 - EP[i])];
    return y;
  endfunction

  function automatic logic [3:0] perm_p4(input logic [3:0] x);
    logic [3:0] y;
    y = '0;
    for (int i = 0; i < 4; i++) y[2'(3 - i)] = x[2'(4 - P4[i])];
    return y;
  endfunction

  // Rotates each 5-bit half of the key left by one position.
  function automatic logic [9:0] ls1(input logic [9:0] x);
    return {x[8:5], x[9], x[3:0], x[4]};
  endfunction

endpackage

// File: rtl/sdes_fk.sv
// sdes_fk: S-DES round function F(R, SK) -- expansion, key mix, S-box lookup, P4.
module sdes_fk
  import sdes_pkg::*;
(
  input  logic [3:0] r,
  input  logic [7:0] subkey,
  output logic [3:0] f
);

  logic [7:0] mixed;
  logic [1:0] s0_out;
  logic [1:0] s1_out;

  // S-box row comes from the outer bits of each nibble, column from the inner pair.
  always_comb begin
    mixed  = perm_ep(r) ^ subkey;
    s0_out = S0[{mixed[7], mixed[4], mixed[6], mixed[5]}];
    s1_out = S1[{mixed[3], mixed[0], mixed[2], mixed[1]}];
    f      = perm_p4({s0_out, s1_out});
  end

endmodule

// File: rtl/sdes_iter_engine.sv
// sdes_iter_engine: registered multi-cycle S-DES encrypt/decrypt engine with valid/ready ports.
// Define SDES_CBC_EN to add cipher-block chaining through an 8-bit chain register seeded from IV.
module sdes_iter_engine
  import sdes_pkg::*;
#(
  parameter logic [7:0] IV = 8'h00
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [9:0] in_key,
  input  logic       in_decrypt,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [9:0] key_q, key_d;
  logic       decrypt_q, decrypt_d;
  logic [7:0] k1_q, k1_d;
  logic [7:0] k2_q, k2_d;
  logic [7:0] work_q, work_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;

  logic [7:0] chain_mask;
  logic [9:0] ks_ls1;
  logic [9:0] ks_ls3;
  logic [7:0] fk_subkey;
  logic [3:0] fk_out;
  logic [7:0] cipher_in;
  logic [7:0] pre_out;

`ifdef SDES_CBC_EN
  logic [7:0] chain_q, chain_d;

  // The chain only advances on a completed output handshake, so abandoned blocks leave it alone.
  always_comb begin
    chain_d = chain_q;
    if (state_q == DONE && out_ready) chain_d = decrypt_q ? data_q : out_data_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) chain_q <= IV;
    else     chain_q <= chain_d;
  end

  assign chain_mask = chain_q;
`else
  logic unused_iv;
  assign chain_mask = 8'h00;
  assign unused_iv  = ^IV;
`endif

  sdes_fk u_fk (
    .r      (work_q[3:0]),
    .subkey (fk_subkey),
    .f      (fk_out)
  );

  // Decryption runs the same Feistel rounds with the subkey order reversed.
  always_comb begin
    ks_ls1    = ls1(perm_p10(key_q));
    ks_ls3    = ls1(ls1(ks_ls1));
    if (state_q == ROUND1) fk_subkey = decrypt_q ? k2_q : k1_q;
    else                   fk_subkey = decrypt_q ? k1_q : k2_q;
    cipher_in = data_q ^ (decrypt_q ? 8'h00 : chain_mask);
    pre_out   = perm_ip_inv({work_q[7:4] ^ fk_out, work_q[3:0]});
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    key_d       = key_q;
    decrypt_d   = decrypt_q;
    k1_d        = k1_q;
    k2_d        = k2_q;
    work_d      = work_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d    = in_data;
          key_d     = in_key;
          decrypt_d = in_decrypt;
          state_d   = KEYGEN;
        end
      end
      KEYGEN: begin
        k1_d    = perm_p8(ks_ls1);
        k2_d    = perm_p8(ks_ls3);
        work_d  = perm_ip(cipher_in);
        state_d = ROUND1;
      end
      ROUND1: begin
        work_d  = {work_q[3:0], work_q[7:4] ^ fk_out};
        state_d = ROUND2;
      end
      ROUND2: begin
        out_data_d  = pre_out ^ (decrypt_q ? chain_mask : 8'h00);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= 8'h00;
      key_q       <= 10'h000;
      decrypt_q   <= 1'b0;
      k1_q        <= 8'h00;
      k2_q        <= 8'h00;
      work_q      <= 8'h00;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      key_q       <= key_d;
      decrypt_q   <= decrypt_d;
      k1_q        <= k1_d;
      k2_q        <= k2_d;
      work_q      <= work_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_sdes_iter_engine.sv
// tb_sdes_iter_engine: directed self-checking bench for sdes_iter_engine using hand-computed S-DES vectors.
// The chained-mode section is compiled in when SDES_CBC_EN is defined.
module tb_sdes_iter_engine;

`ifdef SDES_CBC_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  localparam logic [9:0] KEY = 10'b1010000010;

  typedef struct packed {
    logic [7:0] d;
    logic [9:0] k;
    logic       dec;
    logic [7:0] exp;
  } vec_t;

  localparam vec_t VECS [6] = '{
    '{8'h00, 10'h282, 1'b0, 8'hCE},
    '{8'hCE, 10'h282, 1'b1, 8'h00},
    '{8'h00, 10'h000, 1'b0, 8'hF0},
    '{8'hF0, 10'h000, 1'b1, 8'h00},
    '{8'hFF, 10'h3FF, 1'b0, 8'h0F},
    '{8'h0F, 10'h3FF, 1'b1, 8'hFF}
  };

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [9:0] in_key;
  logic       in_decrypt;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdes_iter_engine dut (
    .CLOCK_50   (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_key     (in_key),
    .in_decrypt (in_decrypt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Presents one block, optionally scrambles the inputs right after accept, and waits for the result.
  task automatic applyStimulus(input logic [7:0] d, input logic [9:0] k, input logic dec,
                               input bit scramble, output int lat, output logic [7:0] res);
    int wait_n;
    wait_n     = 0;
    in_data    = d;
    in_key     = k;
    in_decrypt = dec;
    in_valid   = 1'b1;
    while (!in_ready && wait_n < 20) begin
      tick();
      wait_n++;
    end
    checkOutput("accept_wait", 16'(wait_n < 20), 16'd1);
    tick();
    in_valid = 1'b0;
    if (scramble) begin
      in_data    = ~d;
      in_key     = ~k;
      in_decrypt = ~dec;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    res = out_data;
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         lat;
    logic [7:0] res;
    logic       seen;

    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_key     = 10'h000;
    in_decrypt = 1'b0;
    out_ready  = 1'b0;
    doReset();

    checkOutput("rst_in_ready", 16'(in_ready), 16'd1);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_out_data", 16'(out_data), 16'h00);

    // Classic encrypt vector, including subkeys and single-cycle out_valid.
    out_ready = 1'b1;
    applyStimulus(8'b10010111, KEY, 1'b0, 1'b0, lat, res);
    checkOutput("enc_latency", 16'(lat), 16'd3);
    checkOutput("enc_data", 16'(res), 16'h38);
    checkOutput("enc_k1", 16'(dut.k1_q), 16'b10100100);
    checkOutput("enc_k2", 16'(dut.k2_q), 16'b01000011);
    tick();
    checkOutput("enc_valid_drop", 16'(out_valid), 16'd0);
    checkOutput("enc_back_idle", 16'(in_ready), 16'd1);

    doReset();
    applyStimulus(8'b00111000, KEY, 1'b1, 1'b0, lat, res);
    checkOutput("dec_latency", 16'(lat), 16'd3);
    checkOutput("dec_data", 16'(res), 16'h97);
    tick();

    // Backpressure with a pending block waiting on in_ready.
    doReset();
    out_ready = 1'b0;
    applyStimulus(8'b10010111, KEY, 1'b0, 1'b0, lat, res);
    checkOutput("bp_first_data", 16'(res), 16'h38);
    in_data    = 8'h38;
    in_key     = KEY;
    in_decrypt = 1'b1;
    in_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("bp_hold_valid", 16'(out_valid), 16'd1);
      checkOutput("bp_hold_data", 16'(out_data), 16'h38);
      checkOutput("bp_hold_ready", 16'(in_ready), 16'd0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("bp_release_valid", 16'(out_valid), 16'd0);
    checkOutput("bp_release_ready", 16'(in_ready), 16'd1);
    checkOutput("bp_release_busy", 16'(busy), 16'd0);
    tick();
    checkOutput("bp_pending_accepted", 16'(busy), 16'd1);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("bp_second_latency", 16'(lat), 16'd3);
    checkOutput("bp_second_data", 16'(out_data), 16'(CBC ? 8'hAF : 8'h97));
    tick();

    // Inputs changed right after accept must not disturb the block in flight.
    doReset();
    applyStimulus(8'h97, KEY, 1'b0, 1'b1, lat, res);
    checkOutput("stable_enc_data", 16'(res), 16'h38);
    tick();
    doReset();
    applyStimulus(8'h38, KEY, 1'b1, 1'b1, lat, res);
    checkOutput("stable_dec_data", 16'(res), 16'h97);
    tick();

    // Reset while in ROUND1 abandons the block.
    out_ready  = 1'b1;
    in_data    = 8'h97;
    in_key     = KEY;
    in_decrypt = 1'b0;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_in_ready", 16'(in_ready), 16'd1);
    checkOutput("midrst_busy", 16'(busy), 16'd0);
    checkOutput("midrst_out_valid", 16'(out_valid), 16'd0);
    checkOutput("midrst_out_data", 16'(out_data), 16'h00);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | out_valid;
    end
    checkOutput("midrst_no_result", 16'(seen), 16'd0);

    // Reset while a result is held drops out_valid.
    out_ready = 1'b0;
    applyStimulus(8'h97, KEY, 1'b0, 1'b0, lat, res);
    checkOutput("donerst_pre_valid", 16'(out_valid), 16'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("donerst_valid", 16'(out_valid), 16'd0);
    checkOutput("donerst_ready", 16'(in_ready), 16'd1);

    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      doReset();
      applyStimulus(VECS[i].d, VECS[i].k, VECS[i].dec, 1'b0, lat, res);
      checkOutput($sformatf("vec%0d_latency", i), 16'(lat), 16'd3);
      checkOutput($sformatf("vec%0d_data", i), 16'(res), 16'(VECS[i].exp));
      tick();
    end

`ifdef SDES_CBC_EN
    doReset();
    applyStimulus(8'b10010111, KEY, 1'b0, 1'b0, lat, res);
    checkOutput("cbc_enc1", 16'(res), 16'b00111000);
    tick();
    applyStimulus(8'b10101111, KEY, 1'b0, 1'b0, lat, res);
    checkOutput("cbc_enc2", 16'(res), 16'b00111000);
    checkOutput("cbc_enc2_latency", 16'(lat), 16'd3);
    tick();
    doReset();
    applyStimulus(8'b00111000, KEY, 1'b1, 1'b0, lat, res);
    checkOutput("cbc_dec1", 16'(res), 16'b10010111);
    tick();
    applyStimulus(8'b00111000, KEY, 1'b1, 1'b0, lat, res);
    checkOutput("cbc_dec2", 16'(res), 16'b10101111);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
